// File: rtl/mdu_ctrl_pkg.sv
//----------------------------------------------------------------------------
// mdu_ctrl_pkg : shared MDU opcodes, FSM state type and default latencies
// Revision     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int CNT_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // Codes 9..15 are undefined and behave as NOP everywhere.
  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op != MDU_NOP) && (op <= MDU_MTLO);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
//----------------------------------------------------------------------------
// mdu_arith : combinational signed/unsigned 32x32 multiply and divide
// Revision  : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mdu_arith (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div0
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] b_safe;

  assign a_ext = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
  assign b_ext = is_signed ? {{32{b[31]}}, b} : {32'b0, b};

  // The low 64 bits of the extended product are exact for both signednesses.
  assign product = a_ext * b_ext;

  assign div0   = (b == 32'd0);
  assign b_safe = div0 ? 32'd1 : b;

  always_comb begin
    quotient  = 32'd0;
    remainder = 32'd0;
    if (is_signed) begin
      quotient  = $signed(a) / $signed(b_safe);
      remainder = $signed(a) % $signed(b_safe);
    end else begin
      quotient  = a / b_safe;
      remainder = a % b_safe;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
//----------------------------------------------------------------------------
// mdu_ctrl : multiply/divide sequencer owning HI/LO, with D-stage stall
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  e_mdu_op,
  input  logic        e_start,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic [3:0]  d_mdu_op,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [31:0]      rs_q;
  logic [31:0]      rt_q;

  logic        arith_signed;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div0;

  assign arith_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);

  mdu_arith u_arith (
    .is_signed (arith_signed),
    .a         (rs_q),
    .b         (rt_q),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= MDU_NOP;
      rs_q  <= '0;
      rt_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (e_start) begin
            op_q  <= e_mdu_op;
            rs_q  <= e_rs;
            rt_q  <= e_rt;
            cnt   <= is_mul_op(e_mdu_op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
            state <= BUSY;
            busy  <= 1'b1;
          end else if (e_mdu_op == MDU_MTHI) begin
            hi <= e_rs;
          end else if (e_mdu_op == MDU_MTLO) begin
            lo <= e_rs;
          end
        end
        BUSY: begin
          // Starts and moves arriving here are illegal and deliberately ignored.
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (is_mul_op(op_q)) begin
              hi <= product[63:32];
              lo <= product[31:0];
            end else if (is_div_op(op_q) && !div0) begin
              hi <= remainder;
              lo <= quotient;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stall = is_mdu_op(d_mdu_op) && (busy || e_start);

  always_comb begin
    mdu_out = 32'd0;
    if (e_mdu_op == MDU_MFHI)
      mdu_out = hi;
    else if (e_mdu_op == MDU_MFLO)
      mdu_out = lo;
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
//----------------------------------------------------------------------------
// tb_mdu_ctrl : directed and randomized checks of mdu_ctrl against a model
// Revision    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_mdu_ctrl;

  localparam logic [3:0] OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MFHI = 4'd5,
                         OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
  localparam logic [3:0] OP_ADD_LIKE = 4'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  e_mdu_op = OP_NOP;
  logic        e_start = 1'b0;
  logic [31:0] e_rs = '0;
  logic [31:0] e_rt = '0;
  logic [3:0]  d_mdu_op = OP_NOP;
  logic        busy;
  logic        stall;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles plus the result computed at issue.
  int          m_left = 0;
  logic        m_pend_wr = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .e_mdu_op (e_mdu_op),
    .e_start  (e_start),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .d_mdu_op (d_mdu_op),
    .busy     (busy),
    .stall    (stall),
    .mdu_out  (mdu_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mdu(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  task automatic model_issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] p;
    int sq, sr;
    m_pend_wr = 1'b1;
    case (op)
      OP_MULT: begin
        p = 64'(longint'(int'(rs)) * longint'(int'(rt)));
        {m_pend_hi, m_pend_lo} = p;
        m_left = 5;
      end
      OP_MULTU: begin
        p = {32'b0, rs} * {32'b0, rt};
        {m_pend_hi, m_pend_lo} = p;
        m_left = 5;
      end
      OP_DIV: begin
        m_left = 10;
        if (rt == 0) m_pend_wr = 1'b0;
        else begin
          sq = int'(rs) / int'(rt);
          sr = int'(rs) % int'(rt);
          m_pend_lo = 32'(sq);
          m_pend_hi = 32'(sr);
        end
      end
      default: begin
        m_left = 10;
        if (rt == 0) m_pend_wr = 1'b0;
        else begin
          m_pend_lo = rs / rt;
          m_pend_hi = rs % rt;
        end
      end
    endcase
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_pend_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend_wr) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (e_start) begin
      model_issue(e_mdu_op, e_rs, e_rt);
    end else if (e_mdu_op == OP_MTHI) begin
      m_hi = e_rs;
    end else if (e_mdu_op == OP_MTLO) begin
      m_lo = e_rs;
    end
  endtask

  // Inputs are driven at the falling edge; outputs checked 1ns later.
  task automatic cycle();
    logic        eb;
    logic [31:0] eo;
    #1;
    eb = (m_left > 0);
    eo = (e_mdu_op == OP_MFHI) ? m_hi : (e_mdu_op == OP_MFLO) ? m_lo : 32'd0;
    chk("busy", 64'(busy), 64'(eb));
    chk("stall", 64'(stall), 64'(is_mdu(d_mdu_op) && (eb || e_start)));
    chk("mdu_out", 64'(mdu_out), 64'(eo));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    e_mdu_op = op;
    e_start  = (op >= OP_MULT) && (op <= OP_DIVU);
    e_rs     = rs;
    e_rt     = rt;
    cycle();
    e_mdu_op = OP_NOP;
    e_start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_len);
    int n = 0;
    while (busy && n < 20) begin
      n++;
      cycle();
    end
    chk(tag, 64'(n), 64'(exp_len));
  endtask

  initial begin
    int stall_n;
    logic [3:0]  op;
    logic [31:0] rs, rt;

    @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_out", 64'(mdu_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle("mult_busy_len", 5);
    chk("mult_hi", 64'(hi), 64'h0FFFFFFFF);
    chk("mult_lo", 64'(lo), 64'h0FFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu_busy_len", 5);
    chk("multu_hi", 64'(hi), 64'h1);
    chk("multu_lo", 64'(lo), 64'h0FFFFFFFE);

    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_busy_len", 10);
    chk("div_lo", 64'(lo), 64'h0FFFFFFFD);
    chk("div_hi", 64'(hi), 64'h1);
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_idle("divu_busy_len", 10);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);

    issue(OP_MTHI, 32'h11111111, 32'd0);
    issue(OP_MTLO, 32'h22222222, 32'd0);
    issue(OP_DIVU, 32'd99, 32'd0);
    wait_idle("div0_busy_len", 10);
    chk("div0_hi", 64'(hi), 64'h11111111);
    chk("div0_lo", 64'(lo), 64'h22222222);

    // MFLO waiting in D behind a MULT in E.
    d_mdu_op = OP_MFLO;
    stall_n  = 0;
    e_mdu_op = OP_MULT; e_start = 1'b1; e_rs = 32'd1000; e_rt = 32'hFFFFFFFD;
    #1;
    if (stall) stall_n++;
    cycle();
    e_mdu_op = OP_NOP; e_start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      #1;
      if (stall) stall_n++;
      cycle();
    end
    chk("mflo_stall_len", 64'(stall_n), 64'd6);
    d_mdu_op = OP_NOP;
    e_mdu_op = OP_MFLO;
    #1;
    chk("mflo_value", 64'(mdu_out), 64'h0FFFFF448);
    cycle();
    e_mdu_op = OP_NOP;

    d_mdu_op = OP_ADD_LIKE;
    issue(OP_MULT, 32'd5, 32'd6);
    #1;
    chk("add_no_stall", 64'(stall), 64'd0);
    wait_idle("add_case_busy", 5);

    // Reset in the third busy cycle of a DIV.
    issue(OP_DIV, 32'd100, 32'd3);
    cycle();
    cycle();
    chk("pre_abort_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    m_left = 0; m_hi = '0; m_lo = '0; m_pend_wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(OP_MULT, 32'd3, 32'd4);
    wait_idle("fresh_mult_busy", 5);
    chk("fresh_lo", 64'(lo), 64'd12);
    chk("fresh_hi", 64'(hi), 64'd0);

    // Illegal start and move while busy must be ignored.
    issue(OP_DIVU, 32'd1000, 32'd7);
    e_mdu_op = OP_MULT; e_start = 1'b1; e_rs = 32'd9; e_rt = 32'd9;
    cycle();
    e_mdu_op = OP_MTHI; e_start = 1'b0; e_rs = 32'hDEADBEEF;
    cycle();
    e_mdu_op = OP_NOP;
    wait_idle("illegal_busy_rest", 8);
    chk("illegal_lo", 64'(lo), 64'd142);
    chk("illegal_hi", 64'(hi), 64'd6);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) rt = 32'd3;
      d_mdu_op = 4'($urandom_range(0, 15));
      e_mdu_op = op;
      e_start  = (op >= OP_MULT) && (op <= OP_DIVU);
      e_rs     = rs;
      e_rt     = rt;
      cycle();
    end
    e_mdu_op = OP_NOP; e_start = 1'b0; d_mdu_op = OP_NOP;
    for (int i = 0; i < 12; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
